issue_ctrl: RTL and testbench

In-order issue controller between the instruction decoder and the execution/writeback stage. It accepts one decoded instruction at a time through a valid/ready handshake and holds it back while any source or destination register is still pending (per-register scoreboard). It routes mul/div to a single non-pipelined long-latency unit and all other ops down a 1-cycle path, and arbitrates the single register-file write port between the two paths. It also keeps a saturating stall-cycle counter.

---
 rtl/issue_ctrl.sv | 175 +++++++++++++++++
 tb/tb_issue_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// issue_ctrl
//   In-order issue controller sitting between the decoder and the
//   execution/writeback stage. Accepts one decoded instruction per cycle,
//   holds it back on register hazards (per-register scoreboard), sends
//   mul/div to a single non-pipelined long-latency unit and everything else
//   down a 1-cycle path, and owns the single register-file write port.
//   A saturating counter records decoder stall cycles.
//
// Parameters
//   MUL_LAT, DIV_LAT : issue-to-writeback latency of mul / div (>= 2)
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   dec_valid      decoded instruction present (held until accepted)
//   dec_rd/rs1/rs2 register indices
//   dec_alu_op     [3:0]==0011 mul, 0100 div, anything else simple
//   dec_reg_write  instruction writes dec_rd
//   dec_ready      instruction can be accepted this cycle (combinational)
//   iss_valid      dec_valid && dec_ready
//   iss_long       issued op goes to the mul/div unit
//   wb_valid/wb_rd registered register-file write strobe and destination
//   busy           scoreboard, bit i = register i has a write pending
//   stall_cnt      saturating count of cycles with dec_valid && !dec_ready
// -----------------------------------------------------------------------------
module issue_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [10:0] dec_alu_op,
  input  logic        dec_reg_write,
  output logic        dec_ready,
  output logic        iss_valid,
  output logic        iss_long,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] busy,
  output logic [15:0] stall_cnt
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [3:0] OPC_MUL = 4'b0011;
  localparam logic [3:0] OPC_DIV = 4'b0100;

  // State
  logic [31:0]      busy_q,      busy_d;
  logic             wb_valid_q,  wb_valid_d;
  logic [4:0]       wb_rd_q,     wb_rd_d;
  logic [0:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [4:0]       long_rd_q,   long_rd_d;
  logic             long_wr_q,   long_wr_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  // Decode
  logic is_mul, is_div, is_long, wr_en, long_done, hazard;
  logic unused_op_bits;

  assign is_mul  = (dec_alu_op[3:0] == OPC_MUL);
  assign is_div  = (dec_alu_op[3:0] == OPC_DIV);
  assign is_long = is_mul || is_div;
  assign wr_en   = dec_reg_write && (dec_rd != 5'd0);
  assign unused_op_bits = ^dec_alu_op[10:4];

  // Long unit delivers its result at the edge ending this cycle.
  assign long_done = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));

  // No bypass: a pending register blocks readers and writers until the
  // edge after its writeback. A simple writer must also yield the port to a
  // long op finishing this cycle.
  assign hazard = busy_q[dec_rs1]
               || busy_q[dec_rs2]
               || (dec_reg_write && busy_q[dec_rd])
               || (is_long && (state_q != ST_IDLE))
               || (!is_long && dec_reg_write && long_done);

  assign dec_ready = reset && !hazard;
  assign iss_valid = dec_valid && dec_ready;
  assign iss_long  = iss_valid && is_long;

  // Next-state logic
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    busy_d      = busy_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    long_rd_d   = long_rd_q;
    long_wr_d   = long_wr_q;
    stall_cnt_d = stall_cnt_q;

    // Scoreboard: retire the register written this cycle, then mark the new
    // destination. WAW stalling keeps the two from hitting the same bit.
    if (wb_valid_q) busy_d[wb_rd_q] = 1'b0;
    if (iss_valid && wr_en) busy_d[dec_rd] = 1'b1;
    busy_d[0] = 1'b0;

    // Long unit
    case (state_q)
      ST_IDLE: begin
        if (iss_valid && is_long) begin
          state_d   = ST_RUN;
          cnt_d     = is_mul ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);
          long_rd_d = dec_rd;
          long_wr_d = wr_en;
        end
      end
      default: begin
        if (long_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase

    // Writeback port: at most one of these can fire in a cycle.
    if (long_done) begin
      wb_valid_d = long_wr_q;
      wb_rd_d    = long_rd_q;
    end else if (iss_valid && !is_long && wr_en) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = dec_rd;
    end

    if (dec_valid && !dec_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      long_rd_q   <= '0;
      long_wr_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_rd_q   <= long_rd_d;
      long_wr_q   <= long_wr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_issue_ctrl
//   Directed testbench for issue_ctrl (MUL_LAT=3, DIV_LAT=8). Inputs change
//   1 ns after the rising edge; outputs are checked 1-2 ns later, well clear
//   of the next edge. "Cycle N" is the interval after the Nth edge.
// -----------------------------------------------------------------------------
module tb_issue_ctrl;

  localparam logic [10:0] OP_ADDI = 11'h000;
  localparam logic [10:0] OP_ADD  = 11'h001;
  localparam logic [10:0] OP_MUL  = 11'h003;
  localparam logic [10:0] OP_DIV  = 11'h004;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [10:0] dec_alu_op;
  logic        dec_reg_write;
  logic        dec_ready, iss_valid, iss_long, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] busy;
  logic [15:0] stall_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  issue_ctrl #(.MUL_LAT(3), .DIV_LAT(8)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .dec_rd       (dec_rd),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_alu_op   (dec_alu_op),
    .dec_reg_write(dec_reg_write),
    .dec_ready    (dec_ready),
    .iss_valid    (iss_valid),
    .iss_long     (iss_long),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .busy         (busy),
    .stall_cnt    (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic present(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [10:0] op, input logic we);
    dec_valid     = v;
    dec_rd        = rd;
    dec_rs1       = rs1;
    dec_rs2       = rs2;
    dec_alu_op    = op;
    dec_reg_write = we;
    #1;
  endtask

  task automatic idle();
    present(1'b0, 5'd0, 5'd0, 5'd0, OP_ADDI, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base;
    logic        seen_wb;
    int          cyc;

    // ---------------- reset state ----------------
    reset = 1'b0;
    present(1'b1, 5'd5, 5'd1, 5'd2, OP_ADD, 1'b1);
    #10;
    check("rst_busy",      busy,      32'h0);
    check("rst_wb_valid",  wb_valid,  32'h0);
    check("rst_wb_rd",     wb_rd,     32'h0);
    check("rst_stall_cnt", stall_cnt, 32'h0);
    check("rst_dec_ready", dec_ready, 32'h0);
    check("rst_iss_valid", iss_valid, 32'h0);
    idle();
    @(negedge clk);
    reset = 1'b1;
    next_cycle();

    // ---------------- 1: single simple op ----------------
    present(1'b1, 5'd5, 5'd1, 5'd2, OP_ADD, 1'b1);
    check("t1_iss_valid", iss_valid, 32'h1);
    check("t1_iss_long",  iss_long,  32'h0);
    next_cycle();
    idle();
    check("t1_wb_valid", wb_valid, 32'h1);
    check("t1_wb_rd",    wb_rd,    32'd5);
    check("t1_busy5_c1", busy[5],  32'h1);
    next_cycle();
    check("t1_busy5_c2", busy[5],  32'h0);
    check("t1_wb_off",   wb_valid, 32'h0);

    // ---------------- 2: RAW stall ----------------
    next_cycle();
    base = stall_cnt;
    present(1'b1, 5'd5, 5'd1, 5'd2, OP_ADD, 1'b1);
    check("t2_iss0", iss_valid, 32'h1);
    next_cycle();
    present(1'b1, 5'd6, 5'd5, 5'd1, OP_ADD, 1'b1);
    check("t2_ready_c1", dec_ready, 32'h0);
    next_cycle();
    check("t2_iss_c2", iss_valid, 32'h1);
    next_cycle();
    idle();
    check("t2_wb_valid", wb_valid,  32'h1);
    check("t2_wb_rd",    wb_rd,     32'd6);
    check("t2_stall",    stall_cnt, 32'(base + 16'd1));

    // ---------------- 3: writeback port conflict ----------------
    next_cycle();
    base = stall_cnt;
    present(1'b1, 5'd7, 5'd1, 5'd2, OP_MUL, 1'b1);
    check("t3_mul_iss",  iss_valid, 32'h1);
    check("t3_mul_long", iss_long,  32'h1);
    next_cycle();
    present(1'b1, 5'd8, 5'd1, 5'd2, OP_ADD, 1'b1);
    check("t3_add8_iss", iss_valid, 32'h1);
    next_cycle();
    present(1'b1, 5'd9, 5'd1, 5'd2, OP_ADD, 1'b1);
    check("t3_wb8",        wb_rd,     32'd8);
    check("t3_wb8_v",      wb_valid,  32'h1);
    check("t3_add9_stall", dec_ready, 32'h0);
    next_cycle();
    check("t3_wb7",      wb_rd,     32'd7);
    check("t3_wb7_v",    wb_valid,  32'h1);
    check("t3_add9_iss", iss_valid, 32'h1);
    next_cycle();
    idle();
    check("t3_wb9",   wb_rd,     32'd9);
    check("t3_wb9_v", wb_valid,  32'h1);
    check("t3_stall", stall_cnt, 32'(base + 16'd1));

    // ---------------- 4: back-to-back divs ----------------
    next_cycle();
    base = stall_cnt;
    present(1'b1, 5'd10, 5'd1, 5'd2, OP_DIV, 1'b1);
    check("t4_div10_iss", iss_long, 32'h1);
    next_cycle();
    present(1'b1, 5'd11, 5'd1, 5'd2, OP_DIV, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("t4_ready_c%0d", c), dec_ready, 32'h0);
      next_cycle();
    end
    check("t4_wb10",       wb_rd,     32'd10);
    check("t4_wb10_v",     wb_valid,  32'h1);
    check("t4_div11_iss",  iss_valid, 32'h1);
    check("t4_stall",      stall_cnt, 32'(base + 16'd7));
    next_cycle();
    idle();
    check("t4_busy10_clr", busy[10], 32'h0);
    check("t4_busy11_set", busy[11], 32'h1);
    repeat (6) next_cycle();
    check("t4_quiet_c15", wb_valid, 32'h0);
    next_cycle();
    check("t4_wb11",   wb_rd,    32'd11);
    check("t4_wb11_v", wb_valid, 32'h1);

    // ---------------- 5: x0 destination ----------------
    next_cycle();
    present(1'b1, 5'd0, 5'd1, 5'd2, OP_ADDI, 1'b1);
    check("t5_iss", iss_valid, 32'h1);
    next_cycle();
    present(1'b1, 5'd3, 5'd0, 5'd0, OP_ADD, 1'b1);
    check("t5_busy",     busy,      32'h0);
    check("t5_no_wb",    wb_valid,  32'h0);
    check("t5_rd_x0_ok", dec_ready, 32'h1);
    next_cycle();
    idle();
    next_cycle();

    // ---------------- 6: reset mid-div, then saturation ----------------
    present(1'b1, 5'd12, 5'd1, 5'd2, OP_DIV, 1'b1);
    check("t6_div_iss", iss_long, 32'h1);
    next_cycle();
    present(1'b1, 5'd13, 5'd1, 5'd2, OP_DIV, 1'b1);
    repeat (3) next_cycle();
    check("t6_busy12", busy[12], 32'h1);
    reset = 1'b0;
    #1;
    check("t6_rst_busy",  busy,      32'h0);
    check("t6_rst_wb",    wb_valid,  32'h0);
    check("t6_rst_stall", stall_cnt, 32'h0);
    check("t6_rst_ready", dec_ready, 32'h0);
    idle();
    repeat (2) next_cycle();
    @(negedge clk);
    reset = 1'b1;
    seen_wb = 1'b0;
    repeat (12) begin
      next_cycle();
      if (wb_valid) seen_wb = 1'b1;
    end
    check("t6_no_wb_after", seen_wb, 32'h0);
    check("t6_busy_after",  busy,    32'h0);

    // A div with no writeback presented continuously stalls 7 of every 8
    // cycles, which drives stall_cnt up to its ceiling.
    present(1'b1, 5'd0, 5'd0, 5'd0, OP_DIV, 1'b0);
    cyc = 0;
    while (stall_cnt != 16'hFFFF && cyc < 80000) begin
      next_cycle();
      cyc++;
    end
    check("t6_sat_reached", stall_cnt, 32'h0000_FFFF);
    repeat (10) next_cycle();
    check("t6_sat_hold", stall_cnt, 32'h0000_FFFF);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
